regfile_sb: RTL



---
 rtl/regfile_sb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: decode-stage register file with two combinational read ports,
// a single-cycle writeback port (A), a load-return port (B), and a per-register
// pending scoreboard plus outstanding-load counter for read-after-load stalls.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   rs_addr/rs_data         read port 1 (bypassed, combinational)
//   rt_addr/rt_data         read port 2 (bypassed, combinational)
//   rd_check[1:0]           rs/rt actually consumed; qualifies hazard
//   wa_en/wa_addr/wa_data   Port A write (ALU/JAL writeback)
//   ld_issue/ld_dst         load issue request and its destination
//   ld_ready                load issue can be accepted this cycle (comb)
//   wb_en/wb_addr/wb_data   Port B write (load return)
//   hazard                  a checked source is pending (comb)
//   outstanding             outstanding-load count
//   err                     sticky protocol-error flag
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  output logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] rt_data,
  input  logic [1:0]      rd_check,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_dst,
  output logic            ld_ready,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            hazard,
  output logic [3:0]      outstanding,
  output logic            err
);

  localparam int unsigned CW = 4;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   out_q, out_d;
  logic            err_q, err_d;

  logic [NREG-1:0] wb_onehot;
  logic [NREG-1:0] pend_vis;
  logic            accept;
  logic            dec;
  logic            wb_spur;
  logic            wa_keep;
  logic            wb_keep;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Read ports: zero register, then load return, then Port A, then storage.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (is_zero(rs_addr))                  rs_data = '0;
    else if (wb_en && wb_addr == rs_addr)  rs_data = wb_data;
    else if (wa_en && wa_addr == rs_addr)  rs_data = wa_data;
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (is_zero(rt_addr))                  rt_data = '0;
    else if (wb_en && wb_addr == rt_addr)  rt_data = wb_data;
    else if (wa_en && wa_addr == rt_addr)  rt_data = wa_data;
  end

  // A return arriving this cycle resolves the hazard on its register.
  assign wb_onehot = wb_en ? (NREG'(1) << wb_addr) : '0;
  assign pend_vis  = pend_q & ~wb_onehot;
  assign hazard    = (rd_check[0] && pend_vis[rs_addr]) ||
                     (rd_check[1] && pend_vis[rt_addr]);

  // No look-ahead: a full counter blocks issue even if a return lands now.
  assign ld_ready = (out_q < CW'(MAX_OUT)) && !(pend_q[ld_dst] && !is_zero(ld_dst));
  assign accept   = ld_issue && ld_ready;

  // Zero-register returns only need a nonzero count to be legitimate.
  assign wb_spur = wb_en && ((out_q == '0) || (!is_zero(wb_addr) && !pend_q[wb_addr]));
  assign dec     = wb_en && (out_q != '0);

  assign wa_keep = wa_en && !is_zero(wa_addr);
  assign wb_keep = wb_en && !is_zero(wb_addr);

  // Next-state: storage, scoreboard, counter and sticky error.
  always_comb begin
    regs_d = regs_q;
    if (wa_keep) regs_d[wa_addr] = wa_data;
    if (wb_keep) regs_d[wb_addr] = wb_data;

    // Clear on return first so a same-register re-issue leaves it pending.
    pend_d = pend_q & ~wb_onehot;
    if (accept && !is_zero(ld_dst)) pend_d[ld_dst] = 1'b1;

    out_d = out_q + CW'(accept) - CW'(dec);

    err_d = err_q
          | wb_spur
          | (wa_en && wb_en && (wa_addr == wb_addr))
          | (wa_keep && pend_q[wa_addr]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      pend_q <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  assign outstanding = out_q;
  assign err         = err_q;

endmodule
